cpu_sequencer: RTL and testbench

- Multi-cycle control FSM for the 8-bit accumulator core.
- Sequences instruction fetch from program memory and pulses the program-counter enable.
- Latches and decodes the 16-bit instruction word, then drives register-file, accumulator and data-memory strobes.
- Holds data-memory accesses until a ready handshake completes, and stops on halt request, PC wrap or memory timeout.

---
 rtl/cpu_sequencer_pkg.sv | 47 ++++
 rtl/cpu_sequencer_if.sv | 46 ++++
 rtl/cpu_sequencer_seq_decode.sv | 49 ++++
 rtl/cpu_sequencer.sv | 145 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg
//   Shared types and constants for the accumulator-core sequencer:
//   FSM state encoding, accumulator source select, opcode set and the
//   bit positions of the fields inside the 16-bit instruction word.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        ACC_RF   = 2'd0,
        ACC_IMM  = 2'd1,
        ACC_DMEM = 2'd2,
        ACC_ALU  = 2'd3
    } acc_sel_t;

    // Opcodes 6..15 are undefined and raise o_illegal.
    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LD  = 4'h1,
        OP_ST  = 4'h2,
        OP_ADD = 4'h3,
        OP_LDM = 4'h4,
        OP_STM = 4'h5
    } full_operation;

    // IR[7:6] value that makes LD take its operand from the immediate.
    localparam logic [1:0] DIRECT_LD = 2'b10;

    localparam int IR_RF_LSB   = 0;
    localparam int IR_RF_MSB   = 1;
    localparam int IR_OP_LSB   = 2;
    localparam int IR_OP_MSB   = 5;
    localparam int IR_MODE_LSB = 6;
    localparam int IR_MODE_MSB = 7;
    localparam int IR_IMM_LSB  = 8;
    localparam int IR_IMM_MSB  = 15;
    localparam int IR_DA_LSB   = 6;
    localparam int IR_DA_MSB   = 15;

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if
//   Bundle of the sequencer's control/bus signals.
//   master : the sequencer (consumes i_*, drives o_*)
//   slave  : the core / environment (drives i_*, consumes o_*)
//   i_start, i_halt_req, i_pc_addr, i_instr, i_dmem_ready  -> sequencer
//   o_pc_ce, o_rf_*, o_acc_*, o_imm, o_dmem_*, o_busy, o_halted,
//   o_error, o_illegal, o_retired                          <- sequencer
interface cpu_sequencer_if #(
    parameter int PC_W = 5
);
    logic            i_start;
    logic            i_halt_req;
    logic [PC_W-1:0] i_pc_addr;
    logic [15:0]     i_instr;
    logic            i_dmem_ready;

    logic            o_pc_ce;
    logic            o_rf_we;
    logic [1:0]      o_rf_addr;
    logic            o_acc_we;
    logic [1:0]      o_acc_sel;
    logic [7:0]      o_imm;
    logic            o_dmem_re;
    logic            o_dmem_we;
    logic [9:0]      o_dmem_addr;
    logic            o_busy;
    logic            o_halted;
    logic            o_error;
    logic            o_illegal;
    logic [7:0]      o_retired;

    modport master (
        input  i_start, i_halt_req, i_pc_addr, i_instr, i_dmem_ready,
        output o_pc_ce, o_rf_we, o_rf_addr, o_acc_we, o_acc_sel, o_imm,
               o_dmem_re, o_dmem_we, o_dmem_addr, o_busy, o_halted,
               o_error, o_illegal, o_retired
    );

    modport slave (
        output i_start, i_halt_req, i_pc_addr, i_instr, i_dmem_ready,
        input  o_pc_ce, o_rf_we, o_rf_addr, o_acc_we, o_acc_sel, o_imm,
               o_dmem_re, o_dmem_we, o_dmem_addr, o_busy, o_halted,
               o_error, o_illegal, o_retired
    );

endinterface

// File: rtl/cpu_sequencer_seq_decode.sv
// seq_decode
//   Purely combinational opcode decode. Produces the EXEC-state strobes
//   and tells the FSM whether the instruction takes the MEM path.
//   i_op      : IR opcode field
//   i_mode    : IR[7:6], selects direct (immediate) LD
//   o_rf_we, o_acc_we, o_acc_sel, o_illegal : EXEC strobes (ungated)
//   o_is_mem  : LDM/STM, go through MEM instead of EXEC
//   o_is_stm  : memory op is a write
module seq_decode
    import cpu_sequencer_pkg::*;
(
    input  logic [3:0] i_op,
    input  logic [1:0] i_mode,
    output logic       o_rf_we,
    output logic       o_acc_we,
    output acc_sel_t   o_acc_sel,
    output logic       o_illegal,
    output logic       o_is_mem,
    output logic       o_is_stm
);

    always_comb begin
        o_rf_we   = 1'b0;
        o_acc_we  = 1'b0;
        o_acc_sel = ACC_RF;
        o_illegal = 1'b0;
        o_is_mem  = 1'b0;
        o_is_stm  = 1'b0;
        case (i_op)
            OP_NOP: ;
            OP_LD: begin
                o_acc_we  = 1'b1;
                o_acc_sel = (i_mode == DIRECT_LD) ? ACC_IMM : ACC_RF;
            end
            OP_ST:  o_rf_we = 1'b1;
            OP_ADD: begin
                o_acc_we  = 1'b1;
                o_acc_sel = ACC_ALU;
            end
            OP_LDM: o_is_mem = 1'b1;
            OP_STM: begin
                o_is_mem = 1'b1;
                o_is_stm = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Multi-cycle control FSM for the 8-bit accumulator core.
//   IDLE -> FETCH -> DECODE -> EXEC|MEM -> FETCH/HALT.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (master) : start/halt control, PC + instruction in, data-memory
//                  ready in; PC enable, RF/ACC/DMEM strobes, status out.
//   Strobes are decoded combinationally from the state and the IR so an
//   asynchronous reset drops every request in the same cycle.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 15,
    parameter bit STOP_AT_WRAP = 1'b1,
    parameter int PC_W         = 5
) (
    input logic             i_clk,
    input logic             i_rst,
    cpu_sequencer_if.master bus
);

    localparam logic [PC_W-1:0] PC_LAST  = '1;
    localparam logic [7:0]      TMO_LAST = 8'(MEM_TIMEOUT - 1);

    seq_state_t  state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [7:0]  retired_q, retired_d;
    logic        error_q, error_d;
    logic        halt_pend_q, halt_pend_d;

    logic     dec_rf_we, dec_acc_we, dec_illegal, dec_is_mem, dec_is_stm;
    acc_sel_t dec_acc_sel;

    seq_decode u_decode (
        .i_op      (ir_q[IR_OP_MSB:IR_OP_LSB]),
        .i_mode    (ir_q[IR_MODE_MSB:IR_MODE_LSB]),
        .o_rf_we   (dec_rf_we),
        .o_acc_we  (dec_acc_we),
        .o_acc_sel (dec_acc_sel),
        .o_illegal (dec_illegal),
        .o_is_mem  (dec_is_mem),
        .o_is_stm  (dec_is_stm)
    );

    logic in_exec, in_mem, busy, mem_done, pc_ce, stop_here;
    acc_sel_t acc_sel;

    assign in_exec  = (state_q == S_EXEC);
    assign in_mem   = (state_q == S_MEM);
    assign busy     = (state_q != S_IDLE) && (state_q != S_HALT);
    assign mem_done = in_mem && bus.i_dmem_ready;
    assign pc_ce    = in_exec || mem_done;

    // A halt request seen at any point of the instruction is honoured at
    // the retire boundary, hence the pending flag alongside the live input.
    assign stop_here = halt_pend_q || bus.i_halt_req ||
                       (STOP_AT_WRAP && (bus.i_pc_addr == PC_LAST));

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        tmo_d       = tmo_q;
        error_d     = error_q;
        halt_pend_d = halt_pend_q;
        retired_d   = retired_q;

        if (busy && bus.i_halt_req) halt_pend_d = 1'b1;
        if (pc_ce) retired_d = retired_q + 8'd1;

        case (state_q)
            S_IDLE: if (bus.i_start) state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = bus.i_instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                tmo_d   = 8'd0;
                state_d = dec_is_mem ? S_MEM : S_EXEC;
            end
            S_EXEC: state_d = stop_here ? S_HALT : S_FETCH;
            S_MEM: begin
                if (bus.i_dmem_ready) begin
                    tmo_d   = 8'd0;
                    state_d = stop_here ? S_HALT : S_FETCH;
                end else if (tmo_q == TMO_LAST) begin
                    // Give up: request drops with the state change, no retire.
                    tmo_d   = 8'd0;
                    error_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_HALT: begin
                if (bus.i_start && !bus.i_halt_req) begin
                    error_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_HALT) halt_pend_d = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            ir_q        <= '0;
            tmo_q       <= '0;
            retired_q   <= '0;
            error_q     <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            tmo_q       <= tmo_d;
            retired_q   <= retired_d;
            error_q     <= error_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    always_comb begin
        acc_sel = ACC_RF;
        if (in_exec && dec_acc_we)       acc_sel = dec_acc_sel;
        else if (mem_done && !dec_is_stm) acc_sel = ACC_DMEM;
    end

    assign bus.o_pc_ce     = pc_ce;
    assign bus.o_rf_we     = in_exec && dec_rf_we;
    assign bus.o_rf_addr   = ir_q[IR_RF_MSB:IR_RF_LSB];
    assign bus.o_acc_we    = (in_exec && dec_acc_we) || (mem_done && !dec_is_stm);
    assign bus.o_acc_sel   = acc_sel;
    assign bus.o_imm       = ir_q[IR_IMM_MSB:IR_IMM_LSB];
    assign bus.o_dmem_re   = in_mem && !dec_is_stm;
    assign bus.o_dmem_we   = in_mem && dec_is_stm;
    assign bus.o_dmem_addr = ir_q[IR_DA_MSB:IR_DA_LSB];
    assign bus.o_busy      = busy;
    assign bus.o_halted    = (state_q == S_HALT);
    assign bus.o_error     = error_q;
    assign bus.o_illegal   = in_exec && dec_illegal;
    assign bus.o_retired   = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
//   Random instruction stream against a transaction-level model: the bench
//   plays program memory and PC, and for each instruction derives the
//   expected cycle-by-cycle strobes from the instruction semantics.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    localparam int MEM_TIMEOUT = 15;
    localparam int PC_W        = 5;

    logic i_clk = 1'b0;
    logic i_rst;

    cpu_sequencer_if #(.PC_W(PC_W)) bus ();

    cpu_sequencer #(
        .MEM_TIMEOUT  (MEM_TIMEOUT),
        .STOP_AT_WRAP (1'b1),
        .PC_W         (PC_W)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] prog [32];
    logic [4:0]  pc;
    logic [7:0]  ret;
    int          wait_q [$] = '{4, 99};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // {pc_ce, rf_we, acc_we, acc_sel[1:0], illegal, dmem_re, dmem_we, busy, halted, error}
    function automatic logic [10:0] ev(bit pce, bit rfw, bit accw, logic [1:0] sel, bit ill,
                                       bit re, bit we, bit bsy, bit hlt, bit err);
        return {pce, rfw, accw, sel, ill, re, we, bsy, hlt, err};
    endfunction

    function automatic logic [10:0] obs();
        return {bus.o_pc_ce, bus.o_rf_we, bus.o_acc_we, bus.o_acc_sel, bus.o_illegal,
                bus.o_dmem_re, bus.o_dmem_we, bus.o_busy, bus.o_halted, bus.o_error};
    endfunction

    function automatic bit rnd();
        return ($urandom_range(0, 1) != 0);
    endfunction

    // One clock: drive inputs, check at the falling edge, move past the rising edge.
    task automatic tick(input bit st, input bit hq, input bit rdy, input logic [10:0] exp,
                        input bit fchk, input logic [19:0] fexp);
        bus.i_start      = st;
        bus.i_halt_req   = hq;
        bus.i_dmem_ready = rdy;
        bus.i_pc_addr    = pc;
        bus.i_instr      = prog[pc];
        @(negedge i_clk);
        chk("ctl", 32'(obs()), 32'(exp));
        chk("retired", 32'(bus.o_retired), 32'(ret));
        if (fchk) chk("fields", 32'({bus.o_imm, bus.o_rf_addr, bus.o_dmem_addr}), 32'(fexp));
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_instr(output bit stopped, output bit err);
        logic [15:0] w;
        logic [3:0]  op;
        logic [19:0] f;
        logic [1:0]  sel;
        int          hc, wt;
        bit          hq, hany, rtr, stm, last, accw, rfw, ill;
        w    = prog[pc];
        op   = w[5:2];
        f    = {w[15:8], w[1:0], w[15:6]};
        hc   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
        hany = 0; stopped = 0; err = 0; rtr = 0;

        hq = (hc == 0); hany |= hq;
        tick(0, hq, rnd(), ev(0, 0, 0, 2'd0, 0, 0, 0, 1, 0, 0), 0, f);   // fetch
        hq = (hc == 1); hany |= hq;
        tick(0, hq, rnd(), ev(0, 0, 0, 2'd0, 0, 0, 0, 1, 0, 0), 1, f);   // decode

        if (op == OP_LDM || op == OP_STM) begin
            stm = (op == OP_STM);
            wt  = (wait_q.size() > 0) ? wait_q.pop_front() : int'($urandom_range(0, 19));
            if (wt < MEM_TIMEOUT) begin
                for (int k = 0; k <= wt; k++) begin
                    last = (k == wt);
                    hq = (hc == 2 + k); hany |= hq;
                    tick(0, hq, last, ev(last, 0, last && !stm, (last && !stm) ? 2'd2 : 2'd0,
                                         0, !stm, stm, 1, 0, 0), 1, f);
                end
                rtr = 1;
            end else begin
                for (int k = 0; k < MEM_TIMEOUT; k++) begin
                    hq = (hc == 2 + k); hany |= hq;
                    tick(0, hq, 0, ev(0, 0, 0, 2'd0, 0, !stm, stm, 1, 0, 0), 1, f);
                end
                stopped = 1; err = 1;
            end
        end else begin
            rfw = 0; accw = 0; sel = 2'd0; ill = 0;
            case (op)
                OP_NOP: ;
                OP_LD:  begin accw = 1; sel = (w[7:6] == 2'b10) ? 2'd1 : 2'd0; end
                OP_ST:  rfw = 1;
                OP_ADD: begin accw = 1; sel = 2'd3; end
                default: ill = 1;
            endcase
            hq = (hc == 2); hany |= hq;
            tick(0, hq, rnd(), ev(1, rfw, accw, sel, ill, 0, 0, 1, 0, 0), 1, f);
            rtr = 1;
        end

        if (rtr) begin
            ret = ret + 8'd1;
            if (hany || pc == 5'd31) stopped = 1;
            pc = pc + 5'd1;
        end
    endtask

    task automatic halt_phase(input bit err);
        int n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++)
            tick(0, rnd(), rnd(), ev(0, 0, 0, 2'd0, 0, 0, 0, 0, 1, err), 0, 20'd0);
        // start together with halt_req must keep the sequencer halted
        if (rnd()) tick(1, 1, rnd(), ev(0, 0, 0, 2'd0, 0, 0, 0, 0, 1, err), 0, 20'd0);
        tick(1, 0, rnd(), ev(0, 0, 0, 2'd0, 0, 0, 0, 0, 1, err), 0, 20'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        bit stopped, err;
        logic [3:0] op;
        i_rst = 1'b1;
        bus.i_start = 0; bus.i_halt_req = 0; bus.i_dmem_ready = 0;
        bus.i_pc_addr = '0; bus.i_instr = '0;
        pc  = '0;
        ret = '0;

        prog[0] = 16'h0000;                                   // NOP
        prog[1] = {8'hFE, 2'b10, 4'(OP_LD), 2'b11};           // direct LD
        prog[2] = {8'h00, 2'b00, 4'(OP_ST), 2'b11};           // ST r3
        prog[3] = {10'h2A5, 4'(OP_LDM), 2'b01};               // LDM, ready after 4
        prog[4] = {10'h15A, 4'(OP_STM), 2'b10};               // STM, times out
        prog[5] = {10'h0C3, 4'(OP_ADD), 2'b00};               // ADD
        prog[6] = {10'h3FF, 4'hF, 2'b00};                     // undefined opcode
        for (int i = 7; i < 32; i++) begin
            op = rnd() ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
            prog[i] = {10'($urandom_range(0, 1023)), op, 2'($urandom_range(0, 3))};
        end

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_ctl", 32'(obs()), 32'd0);
        chk("rst_fields", 32'({bus.o_imm, bus.o_rf_addr, bus.o_dmem_addr}), 32'd0);
        chk("rst_retired", 32'(bus.o_retired), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        tick(0, 0, rnd(), ev(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0), 1, 20'd0);  // idle
        tick(1, 0, rnd(), ev(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0), 1, 20'd0);  // start sampled

        for (int n = 0; n < 160; n++) begin
            run_instr(stopped, err);
            if (stopped) halt_phase(err);
        end

        // Asynchronous reset while a load is waiting in MEM.
        prog[pc] = {10'h155, 4'(OP_LDM), 2'b00};
        tick(0, 0, 0, ev(0, 0, 0, 2'd0, 0, 0, 0, 1, 0, 0), 0, 20'd0);
        tick(0, 0, 0, ev(0, 0, 0, 2'd0, 0, 0, 0, 1, 0, 0), 0, 20'd0);
        tick(0, 0, 0, ev(0, 0, 0, 2'd0, 0, 1, 0, 1, 0, 0), 0, 20'd0);
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_ctl", 32'(obs()), 32'd0);
        chk("arst_fields", 32'({bus.o_imm, bus.o_rf_addr, bus.o_dmem_addr}), 32'd0);
        chk("arst_retired", 32'(bus.o_retired), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        ret = '0;
        pc  = '0;
        tick(0, 0, 1, ev(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0), 1, 20'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
